// File: rtl/calc_rr_sched.sv
// calc_rr_sched: round-robin command scheduler sharing the add unit (ALU1)
// and the shift unit (ALU2) among four request ports. Each port may have one
// operation in flight; a fixed-latency shadow pipeline per unit returns the
// destination port alongside the ALU result.
//
// hold_ack bit order: bit 3 = port 1 (id 0), bit 0 = port 4 (id 3),
// so a grant to port 1 reads as 4'b1000.
module calc_rr_sched #(
    parameter int ALU_LAT = 2
) (
    input  logic       c_clk,
    input  logic       reset,
    input  logic [3:0] hold1_prio_req,
    input  logic [3:0] hold2_prio_req,
    input  logic [3:0] hold3_prio_req,
    input  logic [3:0] hold4_prio_req,
    output logic [3:0] hold_ack,
    output logic [3:0] alu1_in_cmd,
    output logic [1:0] alu1_in_req_id,
    output logic [3:0] alu2_in_cmd,
    output logic [1:0] alu2_in_req_id,
    output logic       alu1_out_vld,
    output logic [1:0] alu1_out_req_id,
    output logic       alu2_out_vld,
    output logic [1:0] alu2_out_req_id,
    output logic       err_vld,
    output logic [1:0] err_req_id
);

    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    logic [3:0] cmd [4];
    logic [3:0] busy;
    logic [3:0] busy_next;
    logic [1:0] ptr1;
    logic [1:0] ptr2;
    logic [3:0] req1;
    logic [3:0] req2;
    logic [3:0] reqe;
    // {found, id} of the winner for each unit and for the error responder
    logic [2:0] pick1;
    logic [2:0] pick2;
    logic [2:0] picke;
    logic [3:0] ack_next;

    // Completion shadow pipelines: stage k holds the dispatch from k cycles ago
    logic       vld1_pipe [1:ALU_LAT];
    logic [1:0] id1_pipe  [1:ALU_LAT];
    logic       vld2_pipe [1:ALU_LAT];
    logic [1:0] id2_pipe  [1:ALU_LAT];

    function automatic logic is_alu1(input logic [3:0] c);
        return (c == CMD_ADD) || (c == CMD_SUB);
    endfunction

    function automatic logic is_alu2(input logic [3:0] c);
        return (c == CMD_SHL) || (c == CMD_SHR);
    endfunction

    // First requesting id scanning ptr, ptr+1, ... mod 4; ptr = 0 gives lowest id
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) pick = {1'b1, idx};
        end
        return pick;
    endfunction

    assign cmd[0] = hold1_prio_req;
    assign cmd[1] = hold2_prio_req;
    assign cmd[2] = hold3_prio_req;
    assign cmd[3] = hold4_prio_req;

    assign alu1_out_vld    = vld1_pipe[ALU_LAT];
    assign alu1_out_req_id = id1_pipe[ALU_LAT];
    assign alu2_out_vld    = vld2_pipe[ALU_LAT];
    assign alu2_out_req_id = id2_pipe[ALU_LAT];

    // Classify eligible ports and pick one winner per unit plus one error responder
    always_comb begin
        req1 = 4'b0000;
        req2 = 4'b0000;
        reqe = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if ((cmd[i] != 4'd0) && !busy[i]) begin
                req1[i] = is_alu1(cmd[i]);
                req2[i] = is_alu2(cmd[i]);
                reqe[i] = !is_alu1(cmd[i]) && !is_alu2(cmd[i]);
            end
        end
        pick1 = rr_pick(req1, ptr1);
        pick2 = rr_pick(req2, ptr2);
        picke = rr_pick(reqe, 2'd0);
    end

    // Acks and busy update; a completing port is still busy, so it can never be regranted the same cycle
    always_comb begin
        ack_next  = 4'b0000;
        busy_next = busy;
        if (alu1_out_vld) busy_next[alu1_out_req_id] = 1'b0;
        if (alu2_out_vld) busy_next[alu2_out_req_id] = 1'b0;
        if (pick1[2]) begin
            ack_next[pick1[1:0]]  = 1'b1;
            busy_next[pick1[1:0]] = 1'b1;
        end
        if (pick2[2]) begin
            ack_next[pick2[1:0]]  = 1'b1;
            busy_next[pick2[1:0]] = 1'b1;
        end
        if (picke[2]) ack_next[picke[1:0]] = 1'b1;
    end

    // Registered grant stage: dispatch, ack, error response, pointers and busy flags
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            alu1_in_cmd    <= 4'd0;
            alu1_in_req_id <= 2'd0;
            alu2_in_cmd    <= 4'd0;
            alu2_in_req_id <= 2'd0;
            err_vld        <= 1'b0;
            err_req_id     <= 2'd0;
            hold_ack       <= 4'b0000;
            busy           <= 4'b0000;
            ptr1           <= 2'd0;
            ptr2           <= 2'd0;
        end else begin
            alu1_in_cmd    <= pick1[2] ? cmd[pick1[1:0]] : 4'd0;
            alu1_in_req_id <= pick1[2] ? pick1[1:0] : 2'd0;
            alu2_in_cmd    <= pick2[2] ? cmd[pick2[1:0]] : 4'd0;
            alu2_in_req_id <= pick2[2] ? pick2[1:0] : 2'd0;
            err_vld        <= picke[2];
            err_req_id     <= picke[2] ? picke[1:0] : 2'd0;
            hold_ack       <= {ack_next[0], ack_next[1], ack_next[2], ack_next[3]};
            busy           <= busy_next;
            if (pick1[2]) ptr1 <= pick1[1:0] + 2'd1;
            if (pick2[2]) ptr2 <= pick2[1:0] + 2'd1;
        end
    end

    // Completion pipelines fed from the registered dispatch; reset flushes in-flight ops
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= ALU_LAT; k++) begin
                vld1_pipe[k] <= 1'b0;
                id1_pipe[k]  <= 2'd0;
                vld2_pipe[k] <= 1'b0;
                id2_pipe[k]  <= 2'd0;
            end
        end else begin
            vld1_pipe[1] <= (alu1_in_cmd != 4'd0);
            id1_pipe[1]  <= alu1_in_req_id;
            vld2_pipe[1] <= (alu2_in_cmd != 4'd0);
            id2_pipe[1]  <= alu2_in_req_id;
            for (int k = 2; k <= ALU_LAT; k++) begin
                vld1_pipe[k] <= vld1_pipe[k-1];
                id1_pipe[k]  <= id1_pipe[k-1];
                vld2_pipe[k] <= vld2_pipe[k-1];
                id2_pipe[k]  <= id2_pipe[k-1];
            end
        end
    end

endmodule

// File: tb/tb_calc_rr_sched.sv
// Testbench for calc_rr_sched: scenario tasks drive the request ports and a
// scoreboard queue per unit holds the expected completion (due cycle, port id).
module tb_calc_rr_sched;

    localparam int LAT = 2;

    typedef struct {
        int         due;
        logic [1:0] id;
    } exp_t;

    logic       c_clk = 1'b0;
    logic       reset;
    logic [3:0] h1, h2, h3, h4;
    logic [3:0] hold_ack;
    logic [3:0] alu1_in_cmd, alu2_in_cmd;
    logic [1:0] alu1_in_req_id, alu2_in_req_id;
    logic       alu1_out_vld, alu2_out_vld, err_vld;
    logic [1:0] alu1_out_req_id, alu2_out_req_id, err_req_id;
    logic [24:0] all_out;

    exp_t q1[$];
    exp_t q2[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    calc_rr_sched #(.ALU_LAT(LAT)) dut (
        .c_clk(c_clk), .reset(reset),
        .hold1_prio_req(h1), .hold2_prio_req(h2), .hold3_prio_req(h3), .hold4_prio_req(h4),
        .hold_ack(hold_ack),
        .alu1_in_cmd(alu1_in_cmd), .alu1_in_req_id(alu1_in_req_id),
        .alu2_in_cmd(alu2_in_cmd), .alu2_in_req_id(alu2_in_req_id),
        .alu1_out_vld(alu1_out_vld), .alu1_out_req_id(alu1_out_req_id),
        .alu2_out_vld(alu2_out_vld), .alu2_out_req_id(alu2_out_req_id),
        .err_vld(err_vld), .err_req_id(err_req_id)
    );

    assign all_out = {hold_ack, alu1_in_cmd, alu1_in_req_id, alu2_in_cmd, alu2_in_req_id,
                      alu1_out_vld, alu1_out_req_id, alu2_out_vld, alu2_out_req_id,
                      err_vld, err_req_id};

    always #5 c_clk = ~c_clk;

    always @(posedge c_clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one clock; returns on the falling edge where outputs are sampled
    task automatic tick();
        @(posedge c_clk);
        @(negedge c_clk);
    endtask

    task automatic set_port(input int id, input logic [3:0] v);
        case (id)
            0: h1 = v;
            1: h2 = v;
            2: h3 = v;
            default: h4 = v;
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1;
        h1 = 4'd0; h2 = 4'd0; h3 = 4'd0; h4 = 4'd0;
        tick();
        reset = 1'b0;
        q1.delete();
        q2.delete();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        checks++;
        if (all_out !== 25'd0) begin
            errors++; $display("FAIL reset_release: outputs=%h need 0", all_out);
        end
        h1 = 4'd1;
        tick();
        checks++;
        if (alu1_in_cmd !== 4'd1) begin
            errors++; $display("FAIL pre_reset_dispatch: alu1_in_cmd=%0d need 1", alu1_in_cmd);
        end
        h1 = 4'd0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (all_out !== 25'd0) begin
            errors++; $display("FAIL async_reset: outputs=%h need 0", all_out);
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < LAT + 2; c++) begin
            tick();
            checks++;
            if (all_out !== 25'd0) begin
                errors++; $display("FAIL reset_idle c=%0d: outputs=%h need 0", c, all_out);
            end
        end
    endtask

    task automatic test_single_add();
        logic ev1, ev2;
        h1 = 4'd1;
        for (int c = 0; c < LAT + 3; c++) begin
            tick();
            if (c == 0) begin
                checks++;
                if (alu1_in_cmd !== 4'd1 || alu1_in_req_id !== 2'd0) begin
                    errors++; $display("FAIL single_dispatch: cmd=%0d id=%0d need cmd=1 id=0", alu1_in_cmd, alu1_in_req_id);
                end
                checks++;
                if (hold_ack !== 4'b1000) begin
                    errors++; $display("FAIL single_ack: hold_ack=%b need 1000", hold_ack);
                end
                q1.push_back('{due: cyc + LAT, id: 2'd0});
                h1 = 4'd0;
            end else begin
                checks++;
                if (alu1_in_cmd !== 4'd0 || hold_ack !== 4'b0000) begin
                    errors++; $display("FAIL single_idle c=%0d: cmd=%0d ack=%b need 0", c, alu1_in_cmd, hold_ack);
                end
            end
            ev1 = q1.size() > 0 && q1[0].due == cyc;
            checks++;
            if (alu1_out_vld !== ev1 || (ev1 && alu1_out_req_id !== q1[0].id)) begin
                errors++; $display("FAIL single_out1 cyc=%0d: vld=%0b id=%0d need vld=%0b", cyc, alu1_out_vld, alu1_out_req_id, ev1);
            end
            if (ev1) q1.delete(0);
            ev2 = q2.size() > 0 && q2[0].due == cyc;
            checks++;
            if (alu2_out_vld !== ev2) begin
                errors++; $display("FAIL single_out2 cyc=%0d: vld=%0b need %0b", cyc, alu2_out_vld, ev2);
            end
            if (ev2) q2.delete(0);
        end
    endtask

    task automatic test_round_robin();
        logic ev1;
        logic [1:0] want;
        h1 = 4'd1; h2 = 4'd1; h3 = 4'd1; h4 = 4'd1;
        for (int c = 0; c < 4 + LAT + 2; c++) begin
            tick();
            if (c < 4) begin
                checks++;
                if (alu1_in_cmd !== 4'd1 || alu1_in_req_id !== 2'(c)) begin
                    errors++; $display("FAIL rr_grant c=%0d: cmd=%0d id=%0d need cmd=1 id=%0d", c, alu1_in_cmd, alu1_in_req_id, c);
                end
                checks++;
                if (hold_ack !== (4'b1000 >> c)) begin
                    errors++; $display("FAIL rr_ack c=%0d: hold_ack=%b need %b", c, hold_ack, 4'b1000 >> c);
                end
                q1.push_back('{due: cyc + LAT, id: 2'(c)});
                set_port(c, 4'd0);
            end else begin
                checks++;
                if (alu1_in_cmd !== 4'd0) begin
                    errors++; $display("FAIL rr_idle c=%0d: cmd=%0d need 0", c, alu1_in_cmd);
                end
            end
            ev1 = q1.size() > 0 && q1[0].due == cyc;
            checks++;
            if (alu1_out_vld !== ev1 || (ev1 && alu1_out_req_id !== q1[0].id)) begin
                errors++; $display("FAIL rr_out1 cyc=%0d: vld=%0b id=%0d need vld=%0b id=%0d", cyc, alu1_out_vld, alu1_out_req_id, ev1, ev1 ? q1[0].id : 2'd0);
            end
            if (ev1) q1.delete(0);
        end
        // pointer has wrapped to 0: ports 1 and 3 request, port 1 first
        h1 = 4'd2; h3 = 4'd1;
        for (int c = 0; c < 2 + LAT + 2; c++) begin
            tick();
            if (c < 2) begin
                want = (c == 0) ? 2'd0 : 2'd2;
                checks++;
                if (alu1_in_cmd !== ((c == 0) ? 4'd2 : 4'd1) || alu1_in_req_id !== want) begin
                    errors++; $display("FAIL rr_wrap c=%0d: cmd=%0d id=%0d need id=%0d", c, alu1_in_cmd, alu1_in_req_id, want);
                end
                q1.push_back('{due: cyc + LAT, id: want});
                set_port(int'(want), 4'd0);
            end
            ev1 = q1.size() > 0 && q1[0].due == cyc;
            checks++;
            if (alu1_out_vld !== ev1 || (ev1 && alu1_out_req_id !== q1[0].id)) begin
                errors++; $display("FAIL rr_wrap_out1 cyc=%0d: vld=%0b id=%0d need vld=%0b", cyc, alu1_out_vld, alu1_out_req_id, ev1);
            end
            if (ev1) q1.delete(0);
        end
    endtask

    task automatic test_parallel();
        logic ev1, ev2;
        h2 = 4'd2; h3 = 4'd5;
        for (int c = 0; c < LAT + 3; c++) begin
            tick();
            if (c == 0) begin
                checks++;
                if (alu1_in_cmd !== 4'd2 || alu1_in_req_id !== 2'd1) begin
                    errors++; $display("FAIL par_alu1: cmd=%0d id=%0d need cmd=2 id=1", alu1_in_cmd, alu1_in_req_id);
                end
                checks++;
                if (alu2_in_cmd !== 4'd5 || alu2_in_req_id !== 2'd2) begin
                    errors++; $display("FAIL par_alu2: cmd=%0d id=%0d need cmd=5 id=2", alu2_in_cmd, alu2_in_req_id);
                end
                checks++;
                if (hold_ack !== 4'b0110) begin
                    errors++; $display("FAIL par_ack: hold_ack=%b need 0110", hold_ack);
                end
                q1.push_back('{due: cyc + LAT, id: 2'd1});
                q2.push_back('{due: cyc + LAT, id: 2'd2});
                h2 = 4'd0; h3 = 4'd0;
            end
            ev1 = q1.size() > 0 && q1[0].due == cyc;
            checks++;
            if (alu1_out_vld !== ev1 || (ev1 && alu1_out_req_id !== q1[0].id)) begin
                errors++; $display("FAIL par_out1 cyc=%0d: vld=%0b id=%0d need vld=%0b", cyc, alu1_out_vld, alu1_out_req_id, ev1);
            end
            if (ev1) q1.delete(0);
            ev2 = q2.size() > 0 && q2[0].due == cyc;
            checks++;
            if (alu2_out_vld !== ev2 || (ev2 && alu2_out_req_id !== q2[0].id)) begin
                errors++; $display("FAIL par_out2 cyc=%0d: vld=%0b id=%0d need vld=%0b", cyc, alu2_out_vld, alu2_out_req_id, ev2);
            end
            if (ev2) q2.delete(0);
        end
    endtask

    task automatic test_invalid();
        logic ev1;
        h4 = 4'hF;
        tick();
        checks++;
        if (err_vld !== 1'b1 || err_req_id !== 2'd3 || hold_ack !== 4'b0001) begin
            errors++; $display("FAIL inv_err: err_vld=%0b id=%0d ack=%b need 1/3/0001", err_vld, err_req_id, hold_ack);
        end
        checks++;
        if (alu1_in_cmd !== 4'd0 || alu2_in_cmd !== 4'd0) begin
            errors++; $display("FAIL inv_nodispatch: alu1=%0d alu2=%0d need 0", alu1_in_cmd, alu2_in_cmd);
        end
        h4 = 4'd1;
        for (int c = 0; c < LAT + 3; c++) begin
            tick();
            if (c == 0) begin
                checks++;
                if (alu1_in_cmd !== 4'd1 || alu1_in_req_id !== 2'd3 || hold_ack !== 4'b0001 || err_vld !== 1'b0) begin
                    errors++; $display("FAIL inv_regrant: cmd=%0d id=%0d ack=%b err=%0b need 1/3/0001/0", alu1_in_cmd, alu1_in_req_id, hold_ack, err_vld);
                end
                q1.push_back('{due: cyc + LAT, id: 2'd3});
                h4 = 4'd0;
            end
            ev1 = q1.size() > 0 && q1[0].due == cyc;
            checks++;
            if (alu1_out_vld !== ev1 || (ev1 && alu1_out_req_id !== q1[0].id)) begin
                errors++; $display("FAIL inv_out1 cyc=%0d: vld=%0b id=%0d need vld=%0b", cyc, alu1_out_vld, alu1_out_req_id, ev1);
            end
            if (ev1) q1.delete(0);
        end
        // two invalid requesters: one response per cycle, lowest id first
        h1 = 4'd3; h2 = 4'd7;
        tick();
        checks++;
        if (err_vld !== 1'b1 || err_req_id !== 2'd0 || hold_ack !== 4'b1000) begin
            errors++; $display("FAIL inv_first: err=%0b id=%0d ack=%b need 1/0/1000", err_vld, err_req_id, hold_ack);
        end
        h1 = 4'd0;
        tick();
        checks++;
        if (err_vld !== 1'b1 || err_req_id !== 2'd1 || hold_ack !== 4'b0100) begin
            errors++; $display("FAIL inv_second: err=%0b id=%0d ack=%b need 1/1/0100", err_vld, err_req_id, hold_ack);
        end
        h2 = 4'd0;
        tick();
        checks++;
        if (err_vld !== 1'b0 || hold_ack !== 4'b0000) begin
            errors++; $display("FAIL inv_done: err=%0b ack=%b need 0/0000", err_vld, hold_ack);
        end
    endtask

    task automatic test_reset_midflight();
        logic ev1;
        h1 = 4'd1;
        tick();
        checks++;
        if (alu1_in_cmd !== 4'd1 || alu1_in_req_id !== 2'd0) begin
            errors++; $display("FAIL mid_dispatch: cmd=%0d id=%0d need 1/0", alu1_in_cmd, alu1_in_req_id);
        end
        h1 = 4'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < LAT + 2; c++) begin
            tick();
            checks++;
            if (alu1_out_vld !== 1'b0) begin
                errors++; $display("FAIL mid_flushed c=%0d: alu1_out_vld=%0b need 0", c, alu1_out_vld);
            end
        end
        h1 = 4'd1;
        for (int c = 0; c < LAT + 3; c++) begin
            tick();
            if (c == 0) begin
                checks++;
                if (alu1_in_cmd !== 4'd1 || alu1_in_req_id !== 2'd0 || hold_ack !== 4'b1000) begin
                    errors++; $display("FAIL mid_regrant: cmd=%0d id=%0d ack=%b need 1/0/1000", alu1_in_cmd, alu1_in_req_id, hold_ack);
                end
                q1.push_back('{due: cyc + LAT, id: 2'd0});
                h1 = 4'd0;
            end
            ev1 = q1.size() > 0 && q1[0].due == cyc;
            checks++;
            if (alu1_out_vld !== ev1 || (ev1 && alu1_out_req_id !== q1[0].id)) begin
                errors++; $display("FAIL mid_out1 cyc=%0d: vld=%0b id=%0d need vld=%0b", cyc, alu1_out_vld, alu1_out_req_id, ev1);
            end
            if (ev1) q1.delete(0);
        end
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: q1=%0d q2=%0d entries left, need 0", q1.size(), q2.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        h1 = 4'd0; h2 = 4'd0; h3 = 4'd0; h4 = 4'd0;
        tick();
        tick();
        test_reset();
        test_single_add();
        do_reset();
        test_round_robin();
        test_parallel();
        test_invalid();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
